// File: rtl/pingpong_framebuffer.sv
// Double-buffered 320x240 RGB332 frame store: writer fills the back buffer, VGA reads the front one.
// Optional macro FB_DOUBLE_BUFFER_EN selects two buffers; undefined gives a single shared buffer.
//
// state   | meaning
// WRITING | writer may fill the back buffer (wr_ready=1)
// PENDING | frame complete, waiting for vblank start to swap (wr_ready=0 when double-buffered)
module pingpong_framebuffer #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int H_VIS = 640,
    parameter int V_VIS = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [19:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        frame_done,
    output logic        wr_ready,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    output logic [7:0]  pix_out,
    output logic        swap_pulse,
    output logic [7:0]  frame_count
);

    localparam int NPIX = H_RES * V_RES;
    localparam int AW   = $clog2(NPIX);

    typedef enum logic {WRITING = 1'b0, PENDING = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        swap;
    logic        vblank_start;
    logic        wr_ok;
    logic        swap_pulse_q;
    logic [7:0]  frame_count_q;
    logic [19:0] row_w;
    logic [19:0] raddr_d;
    logic        vis_d;
    logic [AW-1:0] raddr_q;
    logic        vis_q;
    logic [7:0]  rdata;
    logic [7:0]  pix_q;

    assign vblank_start = (hc == 10'd0) && (vc == 10'(V_VIS));

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        if (vblank_start && (state_q == PENDING || frame_done)) begin
            swap = 1'b1;
        end
        if (swap) begin
            state_d = WRITING;
        end else if (state_q == WRITING && frame_done) begin
            state_d = PENDING;
        end
    end

    // Row multiply is fixed at 320 = 256 + 64.
    assign row_w   = {11'd0, vc[9:1]};
    assign raddr_d = (row_w << 8) + (row_w << 6) + {11'd0, hc[9:1]};
    // The range term is implied by the visible window; it also keeps the RAM index in bounds.
    assign vis_d   = (hc < 10'(H_VIS)) && (vc < 10'(V_VIS)) && (raddr_d < 20'(NPIX));

    assign wr_ok   = wr_en && wr_ready && (wr_addr < 20'(NPIX));

`ifdef FB_DOUBLE_BUFFER_EN
    logic [7:0] mem0 [NPIX];
    logic [7:0] mem1 [NPIX];
    logic       front_sel_q;
    logic       rsel_q;

    assign wr_ready = (state_q == WRITING);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (front_sel_q) begin
                mem0[wr_addr[AW-1:0]] <= wr_data;
            end else begin
                mem1[wr_addr[AW-1:0]] <= wr_data;
            end
        end
    end

    // Buffer select is captured with the address so one fetch never straddles a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel_q <= 1'b0;
            rsel_q      <= 1'b0;
        end else begin
            rsel_q <= front_sel_q;
            if (swap) begin
                front_sel_q <= ~front_sel_q;
            end
        end
    end

    assign rdata = rsel_q ? mem1[raddr_q] : mem0[raddr_q];
`else
    logic [7:0] mem [NPIX];

    assign wr_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rdata = mem[raddr_q];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WRITING;
            swap_pulse_q  <= 1'b0;
            frame_count_q <= 8'd0;
            raddr_q       <= '0;
            vis_q         <= 1'b0;
            pix_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            swap_pulse_q  <= swap;
            if (swap) begin
                frame_count_q <= frame_count_q + 8'd1;
            end
            raddr_q       <= raddr_d[AW-1:0];
            vis_q         <= vis_d;
            pix_q         <= vis_q ? rdata : 8'h00;
        end
    end

    assign pix_out     = pix_q;
    assign swap_pulse  = swap_pulse_q;
    assign frame_count = frame_count_q;

endmodule
